axi4_lite_master_bridge: RTL and testbench
==========================================

# axi4_lite_master_bridge

Initiator-side bridge converting the CPU native memory interface (mem_valid/mem_ready) into single-beat AXI4-lite transactions on the mem_axi_* bus served by the system memory/peripheral responder. Registers each request, drives the AR or AW+W channels with independent handshake tracking, collects the R or B response, and returns one mem_ready pulse. A watchdog counter terminates transactions whose responder never answers, so simulation and FPGA runs fail visibly instead of hanging.

## Interface
- TIMEOUT_CYCLES, 1024: max cycles per transaction before abort; 0 disables the watchdog.
- TIMEOUT_RDATA, 32'hDEAD_BEEF: mem_rdata returned on an aborted read.

- clk  in  1  clock; all logic on posedge.
- rst  in  1  asynchronous, active-high reset.
- mem_valid  in  1  request valid; held until mem_ready.
- mem_instr  in  1  instruction fetch; drives arprot[2].
- mem_addr  in  32  byte address.
- mem_wdata  in  32  write data.
- mem_wstrb  in  4  byte enables; 0 = read, nonzero = write.
- mem_ready  out  1  one-cycle completion pulse.
- mem_rdata  out  32  read data, valid with mem_ready.
- mem_axi_awvalid/awready  out/in  1  write-address handshake; mem_axi_awaddr out 32; mem_axi_awprot out 3 (constant 3'b000).
- mem_axi_wvalid/wready  out/in  1  write-data handshake; mem_axi_wdata out 32; mem_axi_wstrb out 4.
- mem_axi_bvalid/bready  in/out  1  write-response handshake.
- mem_axi_arvalid/arready  out/in  1  read-address handshake; mem_axi_araddr out 32; mem_axi_arprot out 3 ({mem_instr,2'b00}).
- mem_axi_rvalid/rready  in/out  1  read-data handshake; mem_axi_rdata in 32.
- timeout  out  1  one-cycle pulse when the watchdog aborts.
- err_count  out  16  saturating count of aborts.

## Operation
- States: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, DONE.
- IDLE: on mem_valid, capture addr/wdata/wstrb/instr into registers; wstrb==0 -> RD_ADDR, else -> WR_REQ. AXI address/data outputs come only from the capture registers.
- RD_ADDR: arvalid=1 until arready sampled high, then RD_DATA.
- RD_DATA: rready=1; on rvalid, latch mem_axi_rdata into mem_rdata, -> DONE.
- WR_REQ: awvalid and wvalid both raised on entry; each dropped independently after its own ready (aw_done, w_done flags); both done -> WR_RESP. Handshakes in either order or same cycle are legal.
- WR_RESP: bready=1; on bvalid -> DONE.
- DONE: mem_ready=1 for exactly one cycle, -> IDLE.
- Valid signals never deassert before their ready (except watchdog abort); payload stable while valid.
- Watchdog: cycle counter cleared on leaving IDLE, increments every cycle in RD_ADDR/RD_DATA/WR_REQ/WR_RESP. Reaching TIMEOUT_CYCLES: drop all valids/readies, mem_rdata=TIMEOUT_RDATA (reads), pulse timeout, err_count+1 (saturates at 16'hFFFF), -> DONE. Abort is a debug escape; the protocol violation is accepted.

## Timing
- Reset values: all valid/ready outputs 0, mem_ready 0, timeout 0, mem_rdata 0, err_count 0, AXI address/data/strb outputs 0, state IDLE. Reset mid-transaction abandons it immediately; no mem_ready is issued.
- Read latency with zero-wait responder: mem_valid sampled at edge 0; arvalid high cycle 1; arready same cycle -> rready cycle 2; rvalid cycle 2 -> mem_ready cycle 3. Minimum 3 cycles request-to-mem_ready; each responder wait cycle adds one.
- Write minimum: awvalid/wvalid cycle 1, bready cycle 2, mem_ready cycle 3.
- mem_valid seen during DONE is ignored; IDLE samples it the following cycle. No pipelining: one outstanding transaction.
- Abort occurs TIMEOUT_CYCLES cycles after leaving IDLE; mem_ready and timeout asserted together in DONE.

## Test plan
- Read 0x0000_0010, responder arready/rvalid immediate, rdata 0x1234_5678 -> mem_ready at cycle 3, mem_rdata 0x1234_5678, araddr 0x10, arprot 3'b000.
- Instruction read with arready delayed 4 cycles -> arvalid held 5 cycles, arprot 3'b100, araddr stable, mem_ready at cycle 7.
- Write 0x4000_0004 data 0xAABB_CCDD strb 4'b0101, wready 3 cycles before awready -> wvalid drops after its handshake, awvalid held, single bready handshake, one mem_ready.
- Write to 0x2000_0000 with bvalid delayed 2 cycles -> bready held, mem_ready exactly one cycle after bvalid handshake.
- TIMEOUT_CYCLES=8, responder never raises arready -> arvalid drops at cycle 9, timeout and mem_ready pulse, mem_rdata 0xDEAD_BEEF, err_count 1.
- rst asserted mid WR_REQ -> awvalid/wvalid 0 asynchronously, state IDLE, err_count 0, no mem_ready; next request completes normally.

Source files
------------

// File: rtl/axi4_lite_master_bridge.sv
// Native mem_valid/mem_ready requests to single-beat AXI4-lite transfers.
// A watchdog aborts transactions that the responder never answers.
module axi4_lite_master_bridge #(
   parameter int unsigned TIMEOUT_CYCLES = 1024,
   parameter logic [31:0] TIMEOUT_RDATA  = 32'hDEAD_BEEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_valid,
   input  logic        mem_instr,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_wdata,
   input  logic [3:0]  mem_wstrb,
   output logic        mem_ready,
   output logic [31:0] mem_rdata,
   output logic        mem_axi_awvalid,
   input  logic        mem_axi_awready,
   output logic [31:0] mem_axi_awaddr,
   output logic [2:0]  mem_axi_awprot,
   output logic        mem_axi_wvalid,
   input  logic        mem_axi_wready,
   output logic [31:0] mem_axi_wdata,
   output logic [3:0]  mem_axi_wstrb,
   input  logic        mem_axi_bvalid,
   output logic        mem_axi_bready,
   output logic        mem_axi_arvalid,
   input  logic        mem_axi_arready,
   output logic [31:0] mem_axi_araddr,
   output logic [2:0]  mem_axi_arprot,
   input  logic        mem_axi_rvalid,
   output logic        mem_axi_rready,
   input  logic [31:0] mem_axi_rdata,
   output logic        timeout,
   output logic [15:0] err_count
);
   localparam logic [2:0] IDLE    = 3'd0;
   localparam logic [2:0] RD_ADDR = 3'd1;
   localparam logic [2:0] RD_DATA = 3'd2;
   localparam logic [2:0] WR_REQ  = 3'd3;
   localparam logic [2:0] WR_RESP = 3'd4;
   localparam logic [2:0] DONE    = 3'd5;

   localparam bit          WD_EN   = (TIMEOUT_CYCLES != 0);
   localparam logic [31:0] WD_LAST = 32'(TIMEOUT_CYCLES - 1);

   logic [2:0]  state;
   logic [2:0]  state_nx;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [3:0]  wstrb_q;
   logic        instr_q;
   logic        aw_done;
   logic        w_done;
   logic [31:0] wd_cnt;
   logic        busy;
   logic        expired;
   logic        abort;
   logic        ar_hs;
   logic        r_hs;
   logic        aw_hs;
   logic        w_hs;
   logic        b_hs;

   assign mem_axi_araddr  = addr_q;
   assign mem_axi_awaddr  = addr_q;
   assign mem_axi_wdata   = wdata_q;
   assign mem_axi_wstrb   = wstrb_q;
   assign mem_axi_arprot  = {instr_q, 2'b00};
   assign mem_axi_awprot  = 3'b000;

   assign mem_axi_arvalid = (state == RD_ADDR);
   assign mem_axi_rready  = (state == RD_DATA);
   assign mem_axi_awvalid = (state == WR_REQ) && !aw_done;
   assign mem_axi_wvalid  = (state == WR_REQ) && !w_done;
   assign mem_axi_bready  = (state == WR_RESP);
   assign mem_ready       = (state == DONE);

   assign ar_hs = mem_axi_arvalid && mem_axi_arready;
   assign r_hs  = mem_axi_rready && mem_axi_rvalid;
   assign aw_hs = mem_axi_awvalid && mem_axi_awready;
   assign w_hs  = mem_axi_wvalid && mem_axi_wready;
   assign b_hs  = mem_axi_bready && mem_axi_bvalid;

   assign busy    = (state == RD_ADDR) || (state == RD_DATA) ||
                    (state == WR_REQ) || (state == WR_RESP);
   assign expired = WD_EN && busy && (wd_cnt >= WD_LAST);

   // A response arriving on the last watchdog cycle still completes normally.
   always_comb begin
      state_nx = state;
      abort    = 1'b0;
      unique case (state)
         IDLE: begin
            if (mem_valid)
               state_nx = (mem_wstrb == 4'b0000) ? RD_ADDR : WR_REQ;
         end
         RD_ADDR: begin
            if (expired) begin
               abort    = 1'b1;
               state_nx = DONE;
            end else if (ar_hs) begin
               state_nx = RD_DATA;
            end
         end
         RD_DATA: begin
            if (r_hs) begin
               state_nx = DONE;
            end else if (expired) begin
               abort    = 1'b1;
               state_nx = DONE;
            end
         end
         WR_REQ: begin
            if (expired) begin
               abort    = 1'b1;
               state_nx = DONE;
            end else if ((aw_done || aw_hs) && (w_done || w_hs)) begin
               state_nx = WR_RESP;
            end
         end
         WR_RESP: begin
            if (b_hs) begin
               state_nx = DONE;
            end else if (expired) begin
               abort    = 1'b1;
               state_nx = DONE;
            end
         end
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         addr_q    <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         instr_q   <= 1'b0;
         aw_done   <= 1'b0;
         w_done    <= 1'b0;
         wd_cnt    <= '0;
         mem_rdata <= '0;
         timeout   <= 1'b0;
         err_count <= '0;
      end else begin
         state   <= state_nx;
         timeout <= abort;
         wd_cnt  <= busy ? wd_cnt + 32'd1 : 32'd0;
         if (state == IDLE && mem_valid) begin
            addr_q  <= mem_addr;
            wdata_q <= mem_wdata;
            wstrb_q <= mem_wstrb;
            instr_q <= mem_instr;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
         end
         if (aw_hs)
            aw_done <= 1'b1;
         if (w_hs)
            w_done <= 1'b1;
         if (r_hs)
            mem_rdata <= mem_axi_rdata;
         else if (abort && (state == RD_ADDR || state == RD_DATA))
            mem_rdata <= TIMEOUT_RDATA;
         if (abort && err_count != 16'hFFFF)
            err_count <= err_count + 16'd1;
      end
   end
endmodule

// File: tb/tb_axi4_lite_master_bridge.sv
// Bench for axi4_lite_master_bridge: vector table driving a responder
// model, scoreboard of completions, plus reset sequences.
module tb_axi4_lite_master_bridge;
   localparam int unsigned TO      = 8;
   localparam logic [31:0] TO_DATA = 32'hDEAD_BEEF;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_valid;
   logic        mem_instr;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wstrb;
   logic        mem_ready;
   logic [31:0] mem_rdata;
   logic        awvalid, awready, wvalid, wready, bvalid, bready;
   logic        arvalid, arready, rvalid, rready;
   logic [31:0] awaddr, wdata, araddr, rdata;
   logic [2:0]  awprot, arprot;
   logic [3:0]  wstrb;
   logic        timeout;
   logic [15:0] err_count;

   axi4_lite_master_bridge #(
      .TIMEOUT_CYCLES(TO),
      .TIMEOUT_RDATA(TO_DATA)
   ) dut (
      .clk(clk), .rst(rst),
      .mem_valid(mem_valid), .mem_instr(mem_instr),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_wstrb(mem_wstrb), .mem_ready(mem_ready),
      .mem_rdata(mem_rdata),
      .mem_axi_awvalid(awvalid), .mem_axi_awready(awready),
      .mem_axi_awaddr(awaddr), .mem_axi_awprot(awprot),
      .mem_axi_wvalid(wvalid), .mem_axi_wready(wready),
      .mem_axi_wdata(wdata), .mem_axi_wstrb(wstrb),
      .mem_axi_bvalid(bvalid), .mem_axi_bready(bready),
      .mem_axi_arvalid(arvalid), .mem_axi_arready(arready),
      .mem_axi_araddr(araddr), .mem_axi_arprot(arprot),
      .mem_axi_rvalid(rvalid), .mem_axi_rready(rready),
      .mem_axi_rdata(rdata),
      .timeout(timeout), .err_count(err_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        instr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      int          ar_dly;
      int          r_dly;
      int          aw_dly;
      int          w_dly;
      int          b_dly;
      logic [31:0] rsp;
      int          exp_cyc;
      int          exp_ar;
      int          exp_aw;
      int          exp_w;
      int          exp_b;
      logic        exp_to;
   } vec_t;

   typedef struct {
      logic        rd;
      logic [31:0] rdata;
      logic        to;
      logic [15:0] errs;
   } exp_t;

   vec_t        vecs[11];
   exp_t        sb[$];
   int          n_cmp = 0;
   int          n_bad = 0;
   logic [15:0] err_model = 16'd0;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", name, act, req);
      end
   endtask

   task automatic resp_idle();
      awready = 1'b0;
      wready  = 1'b0;
      bvalid  = 1'b0;
      arready = 1'b0;
      rvalid  = 1'b0;
      rdata   = 32'h0;
   endtask

   task automatic run_txn(input vec_t v);
      int   done_cyc = -1;
      int   ar_n = 0, aw_n = 0, w_n = 0, b_n = 0;
      int   r_age = 0, b_age = 0;
      bit   r_pend = 0, b_pend = 0, b_go = 0;
      bit   aw_ok = 0, w_ok = 0;
      bit   pv_ar = 0, pr_ar = 0, pv_aw = 0, pr_aw = 0;
      bit   pv_w = 0, pr_w = 0;
      int   pay_bad = 0, drop_bad = 0;
      exp_t e;
      mem_valid = 1'b1;
      mem_instr = v.instr;
      mem_addr  = v.addr;
      mem_wdata = v.wdata;
      mem_wstrb = v.wstrb;
      resp_idle();
      if (v.exp_to && err_model != 16'hFFFF)
         err_model = err_model + 16'd1;
      sb.push_back('{v.wstrb == 4'b0, v.exp_to ? TO_DATA : v.rsp,
                     v.exp_to, err_model});
      for (int cyc = 1; cyc <= 40; cyc++) begin
         @(posedge clk);
         #1;
         if (pv_ar && !pr_ar && !arvalid && !(mem_ready && timeout))
            drop_bad++;
         if (pv_aw && !pr_aw && !awvalid && !(mem_ready && timeout))
            drop_bad++;
         if (pv_w && !pr_w && !wvalid && !(mem_ready && timeout))
            drop_bad++;
         if (arvalid && (araddr !== v.addr || arprot !== {v.instr, 2'b00}))
            pay_bad++;
         if (awvalid && (awaddr !== v.addr || awprot !== 3'b000))
            pay_bad++;
         if (wvalid && (wdata !== v.wdata || wstrb !== v.wstrb))
            pay_bad++;
         if (mem_ready) begin
            done_cyc = cyc;
            e = sb.pop_front();
            if (e.rd)
               check("rdata", mem_rdata, e.rdata);
            check("timeout", 32'(timeout), 32'(e.to));
            check("err_count", 32'(err_count), 32'(e.errs));
            mem_valid = 1'b0;
            resp_idle();
            break;
         end
         rvalid = r_pend && (r_age >= v.r_dly);
         rdata  = rvalid ? v.rsp : ~v.rsp;
         if (rvalid && rready)
            r_pend = 0;
         else if (r_pend)
            r_age++;
         arready = arvalid && (ar_n >= v.ar_dly);
         if (arvalid)
            ar_n++;
         if (arvalid && arready) begin
            r_pend = 1;
            r_age  = 0;
         end
         bvalid = b_pend && (b_age >= v.b_dly);
         if (bready)
            b_n++;
         if (bvalid && bready)
            b_pend = 0;
         else if (b_pend)
            b_age++;
         awready = awvalid && (aw_n >= v.aw_dly);
         wready  = wvalid && (w_n >= v.w_dly);
         if (awvalid)
            aw_n++;
         if (wvalid)
            w_n++;
         if (awvalid && awready)
            aw_ok = 1;
         if (wvalid && wready)
            w_ok = 1;
         if (aw_ok && w_ok && !b_go) begin
            b_go   = 1;
            b_pend = 1;
            b_age  = 0;
         end
         pv_ar = arvalid; pr_ar = arready;
         pv_aw = awvalid; pr_aw = awready;
         pv_w  = wvalid;  pr_w  = wready;
      end
      if (done_cyc < 0 && sb.size() > 0)
         sb.delete(0);
      check("ready_cycle", done_cyc, v.exp_cyc);
      check("arvalid_cycles", ar_n, v.exp_ar);
      check("awvalid_cycles", aw_n, v.exp_aw);
      check("wvalid_cycles", w_n, v.exp_w);
      check("bready_cycles", b_n, v.exp_b);
      check("payload_stable", pay_bad, 0);
      check("valid_held", drop_bad, 0);
      @(posedge clk);
      #1;
      check("ready_pulse", {mem_ready, timeout}, 2'b00);
   endtask

   initial begin
      #200000;
      $display("FAIL global_time_limit reached");
      $fatal(1);
   end

   initial begin
      vecs[0]  = '{1'b0, 32'h0000_0010, 32'h0, 4'h0, 0, 0, 0, 0, 0,
                   32'h1234_5678, 3, 1, 0, 0, 0, 1'b0};
      vecs[1]  = '{1'b1, 32'h0000_0100, 32'h0, 4'h0, 4, 0, 0, 0, 0,
                   32'h0BAD_F00D, 7, 5, 0, 0, 0, 1'b0};
      vecs[2]  = '{1'b0, 32'h4000_0004, 32'hAABB_CCDD, 4'b0101, 0, 0, 3, 0, 0,
                   32'h0, 6, 0, 4, 1, 1, 1'b0};
      vecs[3]  = '{1'b0, 32'h2000_0000, 32'h1122_3344, 4'b1111, 0, 0, 0, 0, 2,
                   32'h0, 5, 0, 1, 1, 3, 1'b0};
      vecs[4]  = '{1'b0, 32'h0000_0030, 32'h0, 4'h0, 99, 0, 0, 0, 0,
                   32'h7777_7777, 9, 8, 0, 0, 0, 1'b1};
      vecs[5]  = '{1'b0, 32'h0000_0200, 32'hCAFE_F00D, 4'b1000, 0, 0, 0, 2, 0,
                   32'h0, 5, 0, 1, 3, 1, 1'b0};
      vecs[6]  = '{1'b0, 32'h0000_0044, 32'h0, 4'h0, 0, 3, 0, 0, 0,
                   32'h5A5A_A5A5, 6, 1, 0, 0, 0, 1'b0};
      vecs[7]  = '{1'b0, 32'h0000_0300, 32'h0102_0304, 4'b0001, 0, 0, 99, 99, 0,
                   32'h0, 9, 0, 8, 8, 0, 1'b1};
      vecs[8]  = '{1'b0, 32'h0000_0050, 32'h0, 4'h0, 0, 99, 0, 0, 0,
                   32'h6666_6666, 9, 1, 0, 0, 0, 1'b1};
      vecs[9]  = '{1'b0, 32'h0000_0060, 32'h9999_0000, 4'b0011, 0, 0, 2, 2, 0,
                   32'h0, 5, 0, 3, 3, 1, 1'b0};
      vecs[10] = '{1'b1, 32'h0000_0070, 32'h0, 4'h0, 5, 0, 0, 0, 0,
                   32'hFEED_0001, 8, 6, 0, 0, 0, 1'b0};

      rst       = 1'b1;
      mem_valid = 1'b0;
      mem_instr = 1'b0;
      mem_addr  = 32'h0;
      mem_wdata = 32'h0;
      mem_wstrb = 4'h0;
      resp_idle();
      #1;
      check("rst_valids", {arvalid, awvalid, wvalid, rready, bready}, 5'b0);
      check("rst_ready", {mem_ready, timeout}, 2'b00);
      check("rst_rdata", mem_rdata, 32'h0);
      check("rst_err", 32'(err_count), 32'h0);
      check("rst_addr", araddr | awaddr, 32'h0);
      check("rst_wpath", {wdata, wstrb, arprot, awprot}, 42'h0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      for (int i = 0; i < 11; i++)
         run_txn(vecs[i]);

      // write held in WR_REQ, then reset lands between clock edges
      mem_valid = 1'b1;
      mem_instr = 1'b0;
      mem_addr  = 32'h7000_0000;
      mem_wdata = 32'h1357_9BDF;
      mem_wstrb = 4'hF;
      sb.push_back('{1'b0, 32'h0, 1'b0, err_model});
      repeat (3) @(posedge clk);
      #1;
      check("pre_rst_wreq", {awvalid, wvalid}, 2'b11);
      check("pre_rst_err", 32'(err_count), 32'd3);
      #2;
      rst = 1'b1;
      #1;
      check("async_rst_valids", {awvalid, wvalid, bready}, 3'b000);
      check("async_rst_ready", {mem_ready, timeout}, 2'b00);
      check("async_rst_err", 32'(err_count), 32'h0);
      sb.delete();
      err_model = 16'd0;
      mem_valid = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      begin
         int stray = 0;
         for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            if (mem_ready || awvalid || wvalid || arvalid)
               stray++;
         end
         check("post_rst_quiet", stray, 0);
      end
      run_txn(vecs[0]);
      run_txn(vecs[3]);
      check("sb_empty", sb.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
